muldiv_seq_unit: RTL and testbench
==================================

// Module: muldiv_seq_unit
// PURPOSE
// Iterative RV32M multiply/divide sequencer attached to the Execute stage beside the single-cycle ALU.
// Accepts one M-extension op from EX using the already-forwarded rs1/rs2 values.
// Stalls the pipeline while it iterates, then presents one result for EX/MEM write-back.
// Shares the EX forwarding muxes; owns its own datapath and FSM.
// PARAMETERS
// XLEN   32  datapath width (from riscv_pkg); unit is verified at 32 only
// PORTS
// clk           in   1     core clock
// rst           in   1     asynchronous, active-high reset
// start         in   1     EX holds a valid M-extension op (funct7==0000001, OP opcode)
// funct3        in   3     M op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
// op_a          in   XLEN  forwarded rs1 value
// op_b          in   XLEN  forwarded rs2 value
// flush         in   1     EX instruction killed (branch taken/redirect); abort op
// stall         out  1     hold IF/ID/EX; EX instruction must not advance
// result_valid  out  1     1-cycle pulse: result holds final value, pipeline advances
// result        out  XLEN  M-op result (low/high product, quotient, or remainder)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; stall=0, result_valid=0, result=0; internal regs cleared.
// - FSM states are IDLE, PREP, CALC, DONE.
//   - IDLE->PREP when start && !flush.
//     - funct3 and op_a/op_b are latched at this edge.
//     - Later changes on these inputs are ignored until IDLE.
//   - PREP (1 cycle): compute operand magnitudes and result sign; detect special cases.
//     - Normal path: go to CALC with iteration counter=0.
//     - Special case: go straight to DONE.
//   - CALC: one iteration per cycle.
//     - Multiply: radix-2 shift-add into a 64-bit product register.
//     - Divide: restoring shift-subtract.
//     - CALC->DONE when the counter reaches XLEN-1. The counter is 5-bit; it must not wrap before the exit.
//   - DONE (1 cycle): apply sign fixup; result_valid=1, result updated; then ->IDLE.
// - Latency, counted from the accepting edge to result_valid high:
//   - normal ops: XLEN+2 = 34 cycles;
//   - special cases: 2 cycles.
// - stall = (state==IDLE && start && !flush) || state==PREP || state==CALC. stall is 0 in DONE.
// - start asserted during DONE is ignored. The EX instruction advances during DONE, so a new op arrives in IDLE next cycle.
// - result holds its last value between ops. result_valid is never high outside DONE.
// - Signedness:
//   - MUL, MULH, DIV, REM: both operands signed.
//   - MULHSU: op_a signed, op_b unsigned.
//   - MULHU, DIVU, REMU: unsigned.
//   - Signed inputs are converted to magnitude, then the 64-bit product or the quotient/remainder is negated in DONE as needed.
//   - MUL returns product[31:0]; MULH* return product[63:32].
//   - Remainder takes the sign of the dividend.
// - Special cases (RISC-V spec, no trap):
//   - Divide by zero: quotient=0xFFFFFFFF, remainder=op_a.
//   - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
//   - Multiply by zero is NOT special; it takes the full latency.
// - flush in any state: next state IDLE, no result_valid, result unchanged.
//   - flush together with start in IDLE: op not accepted, stall=0.
//   - flush during DONE: result_valid still suppressed.
// - Reset during CALC: immediate return to IDLE; no partial result is visible.
// STRUCTURE
// - riscv_pkg gains:
//   - F3_MUL..F3_REMU funct3 constants;
//   - muldiv_state_t enum {IDLE, PREP, CALC, DONE};
//   - F7_MULDIV constant, used by the decoder to raise start.
// - Single module, no sub-module. The decoder and hazard unit OR stall into the existing pipeline stall.
// - The core mux selects result over alu_result when result_valid.
// TESTING
// - MUL 7 * 0xFFFFFFFD -> result_valid exactly 34 cycles after accept, result=0xFFFFFFEB; stall high cycles 0..33.
// - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same inputs -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each in 2 cycles.
// - Start DIV, assert flush in CALC iteration 10 -> IDLE next cycle, no result_valid; next MUL 3*4 -> 12 at 34 cycles.
// - Async rst mid-CALC -> outputs 0 immediately.
//   - start in DONE is ignored.
//   - Back-to-back ops give two pulses, each with the correct result.

Source files
------------

// File: rtl/muldiv_seq_unit_pkg.sv
// Package for the iterative RV32M multiply/divide unit.
// Holds the datapath width, the M-extension funct3/funct7 encodings, the FSM
// state type and small helpers that classify an op by its funct3.
package muldiv_seq_unit_pkg;

  localparam int XLEN = 32;

  // funct7 value the decoder matches (with the OP opcode) to raise start.
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // op_a is signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // op_b is signed for MUL, MULH, DIV, REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// Interface between the Execute stage and the multiply/divide sequencer.
//
// Handshake: EX raises start with funct3/op_a/op_b for an M-extension op;
// the unit accepts it on the clock edge where it is IDLE, start=1 and
// flush=0 (stall rises combinationally in that same cycle). stall then stays
// high until the result cycle, where result_valid pulses for exactly one
// cycle with result holding the final value and EX advances. flush aborts
// whatever is in flight and suppresses result_valid.
//
// master : EX side (drives start/funct3/op_a/op_b/flush)
// slave  : the sequencer (drives stall/result_valid/result/state)
// state is a debug view of the sequencer FSM.
interface muldiv_seq_unit_if;
  import muldiv_seq_unit_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  muldiv_state_t   state;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, result_valid, result, state
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, result_valid, result, state
  );

endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// Latches one op, converts signed operands to magnitudes (PREP), iterates one
// bit per cycle for XLEN cycles (CALC), then applies the sign fixup and
// pulses result_valid (DONE). Divide-by-zero and signed overflow skip CALC.
//
// Ports:
//   clk  - core clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of muldiv_seq_unit_if (start/funct3/op_a/op_b/flush in,
//          stall/result_valid/result/state out)
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  muldiv_seq_unit_if.slave   bus
);

  muldiv_state_t     state_q, state_d;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   dvsr_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q;      // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [4:0]        cnt_q;
  logic              neg_q;      // selected result must be negated in DONE
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              op_div;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic              neg_prep;
  logic [2*XLEN-1:0] special_acc;
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, final_val;

  assign accept = (state_q == IDLE) && bus.start && !bus.flush;
  assign op_div = is_div_op(f3_q);

  // ---------------------------------------------------------------- PREP
  assign a_neg = a_is_signed(f3_q) && a_q[XLEN-1];
  assign b_neg = b_is_signed(f3_q) && b_q[XLEN-1];
  assign mag_a = a_neg ? -a_q : a_q;
  assign mag_b = b_neg ? -b_q : b_q;

  assign div_zero = op_div && (b_q == '0);
  assign div_ovf  = ((f3_q == F3_DIV) || (f3_q == F3_REM)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special  = div_zero || div_ovf;

  // Remainder follows the dividend; products and quotients follow a^b.
  assign neg_prep = (f3_q == F3_REM) ? a_neg : (a_neg ^ b_neg);

  // Special results are placed straight into {remainder, quotient}.
  assign special_acc = div_zero ? {a_q, {XLEN{1'b1}}}
                                : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------- CALC
  // Multiply: add multiplicand into the high half when the current
  // multiplier bit (acc lo[0]) is set, then shift the whole register right.
  assign mul_addend = acc_q[0] ? dvsr_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not borrow. The
  // remainder stays below the divisor, so bit XLEN of the trial is the borrow.
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, dvsr_q};
  assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // ---------------------------------------------------------------- DONE
  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign div_sel   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_fix   = neg_q ? -div_sel : div_sel;
  assign final_val = op_div             ? div_fix :
                     (f3_q == F3_MUL)   ? prod_fix[XLEN-1:0] :
                                          prod_fix[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.stall        = 1'b0;
    bus.result_valid = 1'b0;
    bus.result       = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = PREP;
          bus.stall = 1'b1;
        end
      end
      PREP: begin
        bus.stall = 1'b1;
        state_d   = special ? DONE : CALC;
      end
      CALC: begin
        bus.stall = 1'b1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.flush) begin
          bus.result_valid = 1'b1;
          bus.result       = final_val;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  assign bus.state = state_q;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvsr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q <= bus.funct3;
            a_q  <= bus.op_a;
            b_q  <= bus.op_b;
          end
        end
        PREP: begin
          cnt_q <= '0;
          if (special) begin
            acc_q  <= special_acc;
            neg_q  <= 1'b0;
            dvsr_q <= '0;
          end else begin
            // Multiplier (mul) or dividend (div) starts in the low half.
            acc_q  <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
            dvsr_q <= op_div ? mag_b : mag_a;
            neg_q  <= neg_prep;
          end
        end
        CALC: begin
          acc_q <= op_div ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
        end
        DONE: begin
          if (!bus.flush) result_q <= final_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed testbench for muldiv_seq_unit: a reference model built from plain
// 64-bit arithmetic, an expected-result queue checked by one compare process
// on every cycle, and literal expectations that pin the model.
module tb_muldiv_seq_unit;
  import muldiv_seq_unit_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_seq_unit_if bus();

  muldiv_seq_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sub;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sub = longint'(ub);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = 64'(sa * sb);  return p[31:0];  end
      F3_MULH:   begin p = 64'(sa * sb);  return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * sub); return p[63:32]; end
      F3_MULHU:  begin p = ua * ub;       return p[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 2;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // ---------------------------------------------------------------- compare process
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_result", bus.result, 32'h0);
        check("rst_valid", 32'(bus.result_valid), 32'h0);
        last_res = '0;
      end else if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.result_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", bus.result, e);
          last_res = e;
        end
      end else begin
        check("hold_result", bus.result, last_res);
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lit, input bit flush_done);
    int          lat;
    logic [31:0] m;
    m = model(f3, a, b);
    check("model_pin", m, exp_lit);
    lat = latency(f3, a, b);
    if (!flush_done) exp_q.push_back(m);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k == 1) begin
          // Later input changes must not disturb the latched op.
          bus.start  = 1'b0;
          bus.funct3 = 3'($urandom_range(0, 7));
          bus.op_a   = $urandom;
          bus.op_b   = $urandom;
        end
      end
      if (k == lat && flush_done) bus.flush = 1'b1;
      #1;
      check("stall", 32'(bus.stall), 32'(k < lat));
      check("valid", 32'(bus.result_valid), 32'(k == lat && !flush_done));
      if (k == lat && !flush_done) check("result", bus.result, exp_lit);
    end
    if (flush_done) begin
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("flush_done_state", 32'(bus.state), 32'(IDLE));
      check("flush_done_valid", 32'(bus.result_valid), 32'h0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("idle_stall", 32'(bus.stall), 32'h0);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  // ---------------------------------------------------------------- main
  initial begin
    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14};
    vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2};
    vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{F3_REM,    32'd5,         32'd0,         32'd5};
    vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{F3_MUL,    32'd0,         32'd12345,     32'd0};
    vecs[13] = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[14] = '{F3_REMU,   32'hFFFF_FFFF, 32'h10,        32'hF};
    vecs[15] = '{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};

    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(bus.state), 32'(IDLE));
    check("reset_stall", 32'(bus.stall), 32'h0);
    check("reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    idle_cycles(2);

    // start during DONE is ignored; the op is taken in the following IDLE cycle
    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    bus.start  = 1'b1;
    bus.funct3 = F3_DIVU;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    #1;
    check("done_start_stall", 32'(bus.stall), 32'h0);
    check("done_start_state", 32'(bus.state), 32'(DONE));
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd9;
    #1;
    check("flush_idle_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush_idle_state", 32'(bus.state), 32'(IDLE));
    idle_cycles(2);

    // flush in CALC iteration 10
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_DIV;
    bus.op_a   = 32'hFFFF_FFF9;
    bus.op_b   = 32'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 12) bus.flush = 1'b1;
      #1;
      check("flush_calc_stall", 32'(bus.stall), 32'h1);
      check("flush_calc_valid", 32'(bus.result_valid), 32'h0);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_calc_state", 32'(bus.state), 32'(IDLE));
    check("flush_calc_stall_after", 32'(bus.stall), 32'h0);
    idle_cycles(3);
    run_op(F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    // flush during DONE suppresses the pulse and keeps the old result
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    idle_cycles(2);

    // async reset mid-CALC
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd11;
    bus.op_b   = 32'd13;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    #1;
    rst = 1'b1;
    #1;
    check("rst_calc_state", 32'(bus.state), 32'(IDLE));
    check("rst_calc_stall", 32'(bus.stall), 32'h0);
    check("rst_calc_valid", 32'(bus.result_valid), 32'h0);
    check("rst_calc_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);
    run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    idle_cycles(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
